// File: rtl/icache_pkg.sv
// Shared types and field geometry for the direct-mapped instruction cache.
package icache_pkg;

   localparam int OFFSET_W = 2;
   localparam int BLOCK_W  = 128;
   localparam int WORD_W   = 32;
   localparam int WORDS    = BLOCK_W / WORD_W;
   localparam int BYTE_W   = 2;                    // PC[1:0], byte-in-word, ignored
   localparam int LINE_LSB = BYTE_W + OFFSET_W;    // first index bit of the PC

   typedef enum logic [1:0] {S_IDLE, S_MEM_READ, S_UPDATE} state_e;

   typedef logic [WORDS-1:0][WORD_W-1:0] block_t;

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the instruction cache: combinational read, synchronous write.
module icache_line_array
   import icache_pkg::*;
#(
   parameter int NUM_BLOCKS = 8,
   parameter int TAG_W      = 3,
   parameter int IDX_W      = $clog2(NUM_BLOCKS)
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [IDX_W-1:0] rd_idx_i,
   output logic             rd_valid_o,
   output logic [TAG_W-1:0] rd_tag_o,
   output block_t           rd_data_o,
   input  logic             we_i,
   input  logic [IDX_W-1:0] wr_idx_i,
   input  logic [TAG_W-1:0] wr_tag_i,
   input  block_t           wr_data_i
);

   logic [NUM_BLOCKS-1:0] valid_q;
   logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
   block_t                data_q [NUM_BLOCKS];

   always_ff @(posedge CLK) begin
      if (RESET)
         valid_q <= '0;
      else if (we_i)
         valid_q[wr_idx_i] <= 1'b1;
   end

   // Tag and data carry no reset; a line is only trusted once its valid bit is set.
   always_ff @(posedge CLK) begin
      if (we_i) begin
         tag_q[wr_idx_i]  <= wr_tag_i;
         data_q[wr_idx_i] <= wr_data_i;
      end
   end

   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_tag_o   = tag_q[rd_idx_i];
   assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped instruction cache: same-cycle hits, stalling block refill on miss.
// Define ICACHE_STATS_EN to add saturating HIT_COUNT / MISS_COUNT outputs.
module instr_cache
   import icache_pkg::*;
#(
   parameter int NUM_BLOCKS = 8,
   parameter int ADDR_W     = 10,
   parameter int MEM_ADDR_W = ADDR_W - LINE_LSB
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [31:0]           PC,
   output logic [WORD_W-1:0]     INSTRUCTION,
   output logic                  BUSYWAIT,
   output logic                  MEM_READ,
   output logic [MEM_ADDR_W-1:0] MEM_ADDRESS,
   input  logic [BLOCK_W-1:0]    MEM_READDATA,
   input  logic                  MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
   ,
   output logic [15:0]           HIT_COUNT,
   output logic [15:0]           MISS_COUNT
`endif
);

   localparam int IDX_W = $clog2(NUM_BLOCKS);
   localparam int TAG_W = ADDR_W - LINE_LSB - IDX_W;

   logic [OFFSET_W-1:0] offset;
   logic [IDX_W-1:0]    idx;
   logic [TAG_W-1:0]    tag;
   logic                unused_pc;

   assign offset    = PC[LINE_LSB-1:BYTE_W];
   assign idx       = PC[LINE_LSB+IDX_W-1:LINE_LSB];
   assign tag       = PC[ADDR_W-1:LINE_LSB+IDX_W];
   assign unused_pc = ^{PC[31:ADDR_W], PC[BYTE_W-1:0]};

   state_e state_q, state_d;
   block_t fill_q;
   logic   line_valid, hit, we;
   logic [TAG_W-1:0] line_tag;
   block_t line_data;

   icache_line_array #(
      .NUM_BLOCKS (NUM_BLOCKS),
      .TAG_W      (TAG_W),
      .IDX_W      (IDX_W)
   ) u_lines (
      .CLK        (CLK),
      .RESET      (RESET),
      .rd_idx_i   (idx),
      .rd_valid_o (line_valid),
      .rd_tag_o   (line_tag),
      .rd_data_o  (line_data),
      .we_i       (we),
      .wr_idx_i   (idx),
      .wr_tag_i   (tag),
      .wr_data_i  (fill_q)
   );

   assign hit = line_valid && (line_tag == tag);

   always_ff @(posedge CLK) begin
      if (RESET)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   // The value still on the bus at the MEM_READ exit edge is the one written in UPDATE.
   always_ff @(posedge CLK) begin
      if (state_q == S_MEM_READ)
         fill_q <= MEM_READDATA;
   end

   always_comb begin
      state_d     = state_q;
      BUSYWAIT    = 1'b1;
      MEM_READ    = 1'b0;
      MEM_ADDRESS = '0;
      INSTRUCTION = '0;
      we          = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (hit) begin
               BUSYWAIT    = 1'b0;
               INSTRUCTION = line_data[offset];
            end else begin
               state_d = S_MEM_READ;
            end
         end
         S_MEM_READ: begin
            MEM_READ    = 1'b1;
            MEM_ADDRESS = MEM_ADDR_W'({tag, idx});
            if (!MEM_BUSYWAIT)
               state_d = S_UPDATE;
         end
         S_UPDATE: begin
            we      = !RESET;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef ICACHE_STATS_EN
   logic [15:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (state_q == S_IDLE && hit && hit_cnt_q != 16'hFFFF)
         hit_cnt_d = hit_cnt_q + 16'd1;
      if (state_q == S_IDLE && !hit && miss_cnt_q != 16'hFFFF)
         miss_cnt_d = miss_cnt_q + 16'd1;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign HIT_COUNT  = hit_cnt_q;
   assign MISS_COUNT = miss_cnt_q;
`endif

endmodule

// File: tb/tb_instr_cache.sv
// Scoreboard bench for instr_cache: fetches push expected words, a monitor pops on BUSYWAIT=0.
`timescale 1ns/1ps
module tb_instr_cache;

   logic         CLK;
   logic         RESET;
   logic [31:0]  PC;
   logic [31:0]  INSTRUCTION;
   logic         BUSYWAIT;
   logic         MEM_READ;
   logic [5:0]   MEM_ADDRESS;
   logic [127:0] MEM_READDATA;
   logic         MEM_BUSYWAIT;
`ifdef ICACHE_STATS_EN
   logic [15:0]  HIT_COUNT;
   logic [15:0]  MISS_COUNT;
`endif

   instr_cache dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .PC           (PC),
      .INSTRUCTION  (INSTRUCTION),
      .BUSYWAIT     (BUSYWAIT),
      .MEM_READ     (MEM_READ),
      .MEM_ADDRESS  (MEM_ADDRESS),
      .MEM_READDATA (MEM_READDATA),
      .MEM_BUSYWAIT (MEM_BUSYWAIT)
`ifdef ICACHE_STATS_EN
      ,
      .HIT_COUNT    (HIT_COUNT),
      .MISS_COUNT   (MISS_COUNT)
`endif
   );

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] exp_q[$];
   logic        mon_en   = 1'b0;
   int          mem_lat  = 4;
   int          mem_cnt  = 0;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Block at address a holds words 0x9+w + (a<<8): block 0 = {C,B,A,9}.
   function automatic logic [127:0] mem_block(input logic [5:0] a);
      logic [127:0] b;
      for (int w = 0; w < 4; w++)
         b[w*32 +: 32] = 32'h9 + 32'(w) + {18'b0, a, 8'b0};
      return b;
   endfunction

   // Memory: MEM_BUSYWAIT high for the first mem_lat cycles of a read, so a
   // read spends mem_lat+1 cycles in MEM_READ. Garbage on the bus otherwise.
   initial begin
      MEM_BUSYWAIT = 1'b0;
      MEM_READDATA = '0;
      forever begin
         @(posedge CLK);
         #2;
         if (MEM_READ) begin
            MEM_BUSYWAIT = (mem_cnt < mem_lat);
            mem_cnt++;
            MEM_READDATA = mem_block(MEM_ADDRESS);
         end else begin
            MEM_BUSYWAIT = 1'b0;
            mem_cnt      = 0;
            MEM_READDATA = {4{32'hDEADBEEF}};
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", name, act, want);
      end
   endtask

   // Monitor: every non-stalled cycle delivers one instruction; stalled cycles read 0.
   initial begin
      logic [31:0] want;
      forever begin
         @(negedge CLK);
         if (mon_en && !RESET) begin
            if (!BUSYWAIT) begin
               checks++;
               if (exp_q.size() == 0) begin
                  failures++;
                  $display("FAIL unexpected_instr got=%h expected=none", INSTRUCTION);
               end else begin
                  want = exp_q.pop_front();
                  if (INSTRUCTION !== want) begin
                     failures++;
                     $display("FAIL instr got=%h expected=%h", INSTRUCTION, want);
                  end
               end
            end else begin
               chk("instr_zero_when_busy", INSTRUCTION, 32'h0);
            end
         end
      end
   end

   // Issue one fetch starting right after a posedge; returns one cycle after it completes.
   task automatic fetch(input logic [31:0] pc, input logic [31:0] want, input int exp_stall,
                        input logic exp_rd, input logic [5:0] exp_addr);
      int          stall   = 0;
      logic        rd_seen = 1'b0;
      logic [5:0]  addr    = '0;
      PC = pc;
      exp_q.push_back(want);
      forever begin
         @(negedge CLK);
         if (MEM_READ) begin
            rd_seen = 1'b1;
            addr    = MEM_ADDRESS;
         end
         if (!BUSYWAIT) break;
         stall++;
         if (stall > 100) break;
         @(posedge CLK);
         #1;
      end
      chk($sformatf("stall_pc%0h", pc), stall, exp_stall);
      chk($sformatf("mem_read_seen_pc%0h", pc), {31'b0, rd_seen}, {31'b0, exp_rd});
      if (exp_rd) chk($sformatf("mem_addr_pc%0h", pc), {26'b0, addr}, {26'b0, exp_addr});
      @(posedge CLK);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      RESET = 1'b1;
      PC    = 32'h0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk("rst_mem_read", {31'b0, MEM_READ}, 32'h0);
      chk("rst_mem_addr", {26'b0, MEM_ADDRESS}, 32'h0);
      chk("rst_busywait_follows_miss", {31'b0, BUSYWAIT}, 32'h1);
      chk("rst_instr", INSTRUCTION, 32'h0);
`ifdef ICACHE_STATS_EN
      chk("rst_hit_count", {16'b0, HIT_COUNT}, 32'h0);
      chk("rst_miss_count", {16'b0, MISS_COUNT}, 32'h0);
`endif
      @(posedge CLK);
      #1;
      RESET  = 1'b0;
      mon_en = 1'b1;

      // Cold miss: 1 detect + 5 MEM_READ + 1 UPDATE = 7 stall cycles.
      mem_lat = 4;
      fetch(32'h0, 32'h9, 7, 1'b1, 6'h00);
      fetch(32'h4, 32'hA, 0, 1'b0, 6'h00);
      fetch(32'h8, 32'hB, 0, 1'b0, 6'h00);
      fetch(32'hC, 32'hC, 0, 1'b0, 6'h00);
`ifdef ICACHE_STATS_EN
      chk("hit_count", {16'b0, HIT_COUNT}, 32'd4);
      chk("miss_count", {16'b0, MISS_COUNT}, 32'd1);
`endif

      // Conflict on index 0, then the evicted line misses again.
      fetch(32'h80, 32'h809, 7, 1'b1, 6'h08);
      fetch(32'h84, 32'h80A, 0, 1'b0, 6'h00);
      fetch(32'h0,  32'h9,   7, 1'b1, 6'h00);
      fetch(32'h14, 32'h10A, 7, 1'b1, 6'h01);

      // Reset in the third MEM_READ cycle aborts the refill of index 4.
      mem_lat = 6;
      PC = 32'h40;
      repeat (3) @(posedge CLK);
      #1;
      RESET = 1'b1;
      @(negedge CLK);
      chk("abort_mem_read_before_edge", {31'b0, MEM_READ}, 32'h1);
      @(posedge CLK);
      @(negedge CLK);
      chk("abort_mem_read_dropped", {31'b0, MEM_READ}, 32'h0);
      chk("abort_mem_addr", {26'b0, MEM_ADDRESS}, 32'h0);
      chk("abort_line_invalid", {31'b0, BUSYWAIT}, 32'h1);
      @(posedge CLK);
      #1;
      RESET = 1'b0;
      fetch(32'h40, 32'h409, 9, 1'b1, 6'h04);
      mem_lat = 4;
      fetch(32'h0, 32'h9, 7, 1'b1, 6'h00);

      // Memory ready at once: MEM_READ lasts a single cycle.
      mem_lat = 0;
      fetch(32'h24, 32'h20A, 3, 1'b1, 6'h02);
      fetch(32'h28, 32'h20B, 0, 1'b0, 6'h00);
      // PC bits above ADDR_W and PC[1:0] do not affect the lookup.
      fetch(32'h0000_0428, 32'h20B, 0, 1'b0, 6'h00);
      fetch(32'h0000_002B, 32'h20B, 0, 1'b0, 6'h00);

      mon_en = 1'b0;
      chk("scoreboard_drained", exp_q.size(), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
